// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush controller for the 4-stage pipeline plus the
// FFT accelerator launch/wait handshake. Hazard priority in RUN is
// taken branch > FFT issue > load-use.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush perf counters;
// without it stall_cycles and flush_events are tied to 0.
//
// state    | meaning
// RUN      | normal flow, hazards resolved combinationally
// FFT_WAIT | pipeline frozen until fft_done or timeout
// DRAIN    | one free cycle so the FFT instruction advances to memory
module hazard_sequencer #(
  parameter int REGW        = 5,
  parameter int FFT_TIMEOUT = 1024,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REGW-1:0] de_rs1,
  input  logic [REGW-1:0] de_rs2,
  input  logic            de_rs1_used,
  input  logic            de_rs2_used,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_mem_rd,
  input  logic            ex_branch_taken,
  input  logic            ex_fft_req,
  input  logic            fft_done,
  output logic            pc_stall,
  output logic            fd_stall,
  output logic            fd_flush,
  output logic            de_stall,
  output logic            de_flush,
  output logic            em_flush,
  output logic            fft_start,
  output logic            fft_timeout_err,
  output logic [1:0]      state,
  output logic [CNTW-1:0] stall_cycles,
  output logic [CNTW-1:0] flush_events
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] FFT_WAIT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;

  localparam int CW = $clog2(FFT_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FFT_TIMEOUT - 1);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [CW-1:0] wait_cnt;
  logic          load_use;
  logic          timeout_hit;

  assign load_use = ex_mem_rd && (ex_rd != '0) &&
                    ((de_rs1_used && (de_rs1 == ex_rd)) ||
                     (de_rs2_used && (de_rs2 == ex_rd)));

  // fft_done takes precedence over a timeout landing in the same cycle
  assign timeout_hit = (state_q == FFT_WAIT) && !fft_done && (wait_cnt == CNT_LAST);

  assign state = state_q;

  // state register, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      wait_cnt        <= '0;
      fft_timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN)
        wait_cnt <= '0;
      else if (state_q == FFT_WAIT && state_d == FFT_WAIT)
        wait_cnt <= wait_cnt + CW'(1);
      if (timeout_hit)
        fft_timeout_err <= 1'b1;
    end
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (!ex_branch_taken && ex_fft_req) state_d = FFT_WAIT;
      FFT_WAIT: if (fft_done || timeout_hit) state_d = DRAIN;
      DRAIN:    state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // stall/flush/launch outputs from state and current hazards
  always_comb begin
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    fd_flush  = 1'b0;
    de_stall  = 1'b0;
    de_flush  = 1'b0;
    em_flush  = 1'b0;
    fft_start = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (ex_fft_req) begin
          fft_start = 1'b1;
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          de_stall  = 1'b1;
          em_flush  = 1'b1;
        end else if (load_use) begin
          pc_stall = 1'b1;
          fd_stall = 1'b1;
          de_flush = 1'b1;
        end
      end
      FFT_WAIT: begin
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_stall = 1'b1;
        em_flush = 1'b1;
      end
      DRAIN: begin
        if (ex_branch_taken) begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  // saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNTW'(1);
      if ((fd_flush || de_flush || em_flush) && (flush_events != '1))
        flush_events <= flush_events + CNTW'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central stall/flush controller for the 4-stage core pipeline. It drives the stall and flush inputs of the fetch/decode, decode/execute and execute/memory pipe registers, and it sequences the FFT accelerator handshake. Three hazard classes are resolved in priority order: taken branch, FFT issue/wait, load-use. Outputs are combinational from state plus current inputs unless noted otherwise.

Parameters:
REGW, 5, register-address width
FFT_TIMEOUT, 1024, max cycles in FFT_WAIT before abort (>=2)
CNTW, 16, perf-counter width (used only with the optional feature)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
de_rs1  input  REGW  source reg 1 of instr in decode
de_rs2  input  REGW  source reg 2 of instr in decode
de_rs1_used  input  1  decode instr reads rs1
de_rs2_used  input  1  decode instr reads rs2
ex_rd  input  REGW  dest reg of instr in execute
ex_mem_rd  input  1  execute instr is a load
ex_branch_taken  input  1  execute instr resolved as a taken branch
ex_fft_req  input  1  execute instr has fft_wr_en set
fft_done  input  1  one-cycle completion pulse from FFT unit
pc_stall  output  1  hold PC
fd_stall  output  1  stall fetch/decode pipe
fd_flush  output  1  flush fetch/decode pipe
de_stall  output  1  stall decode/execute pipe
de_flush  output  1  flush decode/execute pipe (bubble)
em_flush  output  1  flush execute/memory pipe (bubble)
fft_start  output  1  one-cycle FFT launch pulse
fft_timeout_err  output  1  sticky, registered timeout flag
state  output  2  RUN=0, FFT_WAIT=1, DRAIN=2
stall_cycles  output  CNTW  perf counter (see Optional Feature)
flush_events  output  CNTW  perf counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=RUN, timeout counter=0, fft_timeout_err=0, perf counters=0. All combinational outputs are 0 while in RUN with idle inputs.
- load_use = ex_mem_rd & (ex_rd!=0) & ((de_rs1_used & de_rs1==ex_rd) | (de_rs2_used & de_rs2==ex_rd)).
- RUN, priority branch > FFT > load-use:
  - ex_branch_taken: fd_flush=1, de_flush=1 in the same cycle. No stall. Remain in RUN.
  - Else ex_fft_req: fft_start=1 in this cycle; pc_stall, fd_stall and de_stall are all 1; em_flush=1. Next state is FFT_WAIT and the counter is cleared.
  - Else load_use: pc_stall=1, fd_stall=1, de_flush=1 for exactly 1 cycle. Remain in RUN. The next cycle re-evaluates; the load has moved on, so load_use clears.
- FFT_WAIT:
  - pc_stall, fd_stall, de_stall and em_flush are held at 1. fft_start=0. The counter increments each cycle.
  - fft_done=1: outputs unchanged this cycle; next state is DRAIN.
  - No fft_done and counter==FFT_TIMEOUT-1: set fft_timeout_err; next state is DRAIN.
  - ex_branch_taken and load_use are ignored.
- DRAIN (exactly 1 cycle):
  - All stall, flush and fft_start outputs are 0, so the FFT instruction advances to memory.
  - ex_fft_req is masked in this cycle.
  - ex_branch_taken is still honoured (fd_flush, de_flush).
  - load_use is ignored.
  - Next state is RUN.
- Late fft_done (arriving in RUN or DRAIN) is ignored.
- fft_timeout_err is cleared only by reset.
- Reset mid-FFT_WAIT returns to RUN immediately; no fft_start is re-issued.
- Counter width is clog2(FFT_TIMEOUT); it never wraps, because exit occurs at FFT_TIMEOUT-1.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - stall_cycles increments each cycle pc_stall=1.
  - flush_events increments each cycle fd_flush|de_flush|em_flush=1.
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- Load-use: ex_mem_rd=1, ex_rd=3, de_rs1=3, de_rs1_used=1 -> exactly one cycle with pc_stall=fd_stall=de_flush=1. Same stimulus with ex_rd=0 -> no stall.
- Taken branch in RUN with a simultaneous load_use -> fd_flush=de_flush=1, pc_stall=0.
- FFT issue: ex_fft_req=1 at cycle 0, fft_done pulse at cycle 5 -> fft_start high at cycle 0 only; stalls and em_flush high for cycles 0-5; state=DRAIN at cycle 6 with all outputs 0; RUN at cycle 7; no second fft_start.
- Timeout: FFT_TIMEOUT=8, fft_done never asserted -> fft_timeout_err rises after 8 FFT_WAIT cycles; DRAIN then RUN follow; the error stays 1 until rst_n=0.
- Reset mid-FFT_WAIT at cycle 3 -> state=0, all outputs 0 asynchronously; a later fft_done has no effect.
- With HAZARD_PERF_CNT_EN and CNTW=4: 20 stalled cycles -> stall_cycles=15 (saturated). Without the macro -> stall_cycles=0.
